// File: rtl/regulator_trim_pkg.sv
// Shared types for the regulator trim calibrator.
// State, trim and step-direction encodings used by the controller.
package regulator_trim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EVAL,
        ST_LOCKED,
        ST_FAIL
    } state_e;

    typedef logic signed [3:0] trim_t;

    localparam trim_t TRIM_MIN = -4'sd8;
    localparam trim_t TRIM_MAX = 4'sd7;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_e;

    function automatic trim_t trim_step(input trim_t t, input dir_e d);
        trim_t r;
        r = t;
        if (d == DIR_UP && t != TRIM_MAX) begin
            r = t + trim_t'(1);
        end else if (d == DIR_DOWN && t != TRIM_MIN) begin
            r = t - trim_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/trim_settle_timer.sv
// Loadable down-counter timing the regulator settling window.
// expired is high while the count sits at zero.
module trim_settle_timer #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(SETTLE_CYCLES - 1);
        end else if (count && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/regulator_trim_ctrl.sv
// Closed-loop trim calibrator: steps trim one LSB at a time until the
// measured vout code is within tolerance, overshoots, saturates or times out.
module regulator_trim_ctrl
    import regulator_trim_pkg::*;
#(
    parameter int ADC_W         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int MAX_ITER      = 16,
    parameter int INIT_TRIM     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADC_W-1:0]  target_code,
    input  logic [ADC_W-1:0]  tol_code,
    output logic              meas_req,
    input  logic              meas_valid,
    input  logic [ADC_W-1:0]  meas_code,
    output logic signed [3:0] trim,
    output logic              busy,
    output logic              done,
    output logic              locked,
    output logic              fail,
    output logic              inexact
);

    localparam int    ITER_W = $clog2(MAX_ITER + 1);
    localparam trim_t INIT_T = trim_t'(INIT_TRIM);

    state_e             state_q, state_d;
    trim_t              trim_q, trim_d;
    trim_t              prev_trim_q, prev_trim_d;
    logic [ADC_W:0]     prev_abs_q, prev_abs_d;
    dir_e               prev_dir_q, prev_dir_d;
    logic [ADC_W-1:0]   target_q, target_d;
    logic [ADC_W-1:0]   tol_q, tol_d;
    logic [ADC_W-1:0]   meas_q, meas_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic               inexact_q, inexact_d;

    logic               timer_load;
    logic               timer_count;
    logic               timer_expired;

    logic signed [ADC_W:0] err;
    logic [ADC_W:0]        abs_err;
    dir_e                  dir_now;

    trim_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .count  (timer_count),
        .expired(timer_expired)
    );

    // One extra bit keeps the difference of two unsigned codes exact.
    always_comb begin
        err     = $signed({1'b0, meas_q}) - $signed({1'b0, target_q});
        abs_err = err[ADC_W] ? (ADC_W+1)'(-err) : (ADC_W+1)'(err);
        dir_now = err[ADC_W] ? DIR_UP : DIR_DOWN;
    end

    always_comb begin
        state_d     = state_q;
        trim_d      = trim_q;
        prev_trim_d = prev_trim_q;
        prev_abs_d  = prev_abs_q;
        prev_dir_d  = prev_dir_q;
        target_d    = target_q;
        tol_d       = tol_q;
        meas_d      = meas_q;
        iter_d      = iter_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        locked_d    = locked_q;
        fail_d      = fail_q;
        inexact_d   = inexact_q;
        timer_load  = 1'b0;
        timer_count = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_LOCKED, ST_FAIL: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    trim_d     = INIT_T;
                    target_d   = target_code;
                    tol_d      = tol_code;
                    iter_d     = '0;
                    prev_dir_d = DIR_NONE;
                    locked_d   = 1'b0;
                    fail_d     = 1'b0;
                    inexact_d  = 1'b0;
                    busy_d     = 1'b1;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                timer_count = 1'b1;
                if (timer_expired) begin
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (meas_valid) begin
                    meas_d  = meas_code;
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (abs_err <= {1'b0, tol_q}) begin
                    state_d  = ST_LOCKED;
                    locked_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else if (prev_dir_q != DIR_NONE && dir_now != prev_dir_q) begin
                    // Crossed the target: keep the closer side, current wins a tie.
                    state_d   = ST_LOCKED;
                    locked_d  = 1'b1;
                    inexact_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    if (prev_abs_q < abs_err) begin
                        trim_d = prev_trim_q;
                    end
                end else if ((dir_now == DIR_UP && trim_q == TRIM_MAX) ||
                             (dir_now == DIR_DOWN && trim_q == TRIM_MIN)) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (iter_q == ITER_W'(MAX_ITER)) begin
                    state_d = ST_FAIL;
                    fail_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    trim_d      = trim_step(trim_q, dir_now);
                    prev_dir_d  = dir_now;
                    prev_trim_d = trim_q;
                    prev_abs_d  = abs_err;
                    state_d     = ST_SETTLE;
                    timer_load  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trim_q      <= INIT_T;
            prev_trim_q <= INIT_T;
            prev_abs_q  <= '0;
            prev_dir_q  <= DIR_NONE;
            target_q    <= '0;
            tol_q       <= '0;
            meas_q      <= '0;
            iter_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            trim_q      <= trim_d;
            prev_trim_q <= prev_trim_d;
            prev_abs_q  <= prev_abs_d;
            prev_dir_q  <= prev_dir_d;
            target_q    <= target_d;
            tol_q       <= tol_d;
            meas_q      <= meas_d;
            iter_q      <= iter_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            inexact_q   <= inexact_d;
        end
    end

    assign meas_req = (state_q == ST_MEASURE);
    assign trim     = trim_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign locked   = locked_q;
    assign fail     = fail_q;
    assign inexact  = inexact_q;

endmodule

// File: tb/tb_regulator_trim_ctrl.sv
// Scoreboard bench for regulator_trim_ctrl with a linear ADC model
// (code = 165 + 10*trim, answered 3 cycles after meas_req rises).
module tb_regulator_trim_ctrl;

    typedef struct {
        int locked;
        int fail;
        int inexact;
        int trim;
        int nmeas;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] target = '0;
    logic [7:0] tol = '0;

    logic start0 = 1'b0;
    logic inj0 = 1'b0;
    logic req0, val0, busy0, done0, locked0, fail0, inexact0;
    logic aval0;
    logic [7:0] acode0;
    logic [1:0] acnt0;
    logic signed [3:0] trim0;

    logic start1 = 1'b0;
    logic req1, val1, busy1, done1, locked1, fail1, inexact1;
    logic aval1;
    logic [7:0] acode1;
    logic [1:0] acnt1;
    logic signed [3:0] trim1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];
    int nmeas0 = 0, nmeas1 = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int gap0 = 0;
    bit first0 = 1'b0;
    bit prev_req0 = 1'b0;
    bit active0 = 1'b0;
    int busy_bad0 = 0;

    always #5 clk = ~clk;

    assign val0 = aval0 | inj0;
    assign val1 = aval1;

    regulator_trim_ctrl u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start0),
        .target_code(target),
        .tol_code   (tol),
        .meas_req   (req0),
        .meas_valid (val0),
        .meas_code  (acode0),
        .trim       (trim0),
        .busy       (busy0),
        .done       (done0),
        .locked     (locked0),
        .fail       (fail0),
        .inexact    (inexact0)
    );

    regulator_trim_ctrl #(.MAX_ITER(3)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .target_code(target),
        .tol_code   (tol),
        .meas_req   (req1),
        .meas_valid (val1),
        .meas_code  (acode1),
        .trim       (trim1),
        .busy       (busy1),
        .done       (done1),
        .locked     (locked1),
        .fail       (fail1),
        .inexact    (inexact1)
    );

    always @(posedge clk) begin
        if (rst || !req0) begin
            acnt0 <= '0;
            aval0 <= 1'b0;
            acode0 <= '0;
        end else if (aval0) begin
            aval0 <= 1'b0;
        end else if (acnt0 == 2'd2) begin
            aval0 <= 1'b1;
            acode0 <= 8'(165 + 10 * int'(trim0));
        end else begin
            acnt0 <= acnt0 + 2'd1;
        end
    end

    always @(posedge clk) begin
        if (rst || !req1) begin
            acnt1 <= '0;
            aval1 <= 1'b0;
            acode1 <= '0;
        end else if (aval1) begin
            aval1 <= 1'b0;
        end else if (acnt1 == 2'd2) begin
            aval1 <= 1'b1;
            acode1 <= 8'(165 + 10 * int'(trim1));
        end else begin
            acnt1 <= acnt1 + 2'd1;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (req0 && val0) nmeas0++;
            if (req0 && !prev_req0) begin
                check("settle_gap", gap0, first0 ? 16 : 17);
                first0 = 1'b0;
            end
            if (req0) gap0 = 0;
            else if (busy0) gap0++;
            prev_req0 = req0;
            if (active0 && !busy0 && !done0) busy_bad0++;
            if (done0) begin
                exp_t e;
                check("sb0_depth", q0.size(), 1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    check("locked", int'(locked0), e.locked);
                    check("fail", int'(fail0), e.fail);
                    check("inexact", int'(inexact0), e.inexact);
                    check("trim", int'(trim0), e.trim);
                    check("nmeas", nmeas0, e.nmeas);
                end
                check("busy_at_done", int'(busy0), 0);
                check("busy_gaps", busy_bad0, 0);
                active0 = 1'b0;
                done_cnt0++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (req1 && val1) nmeas1++;
            if (done1) begin
                exp_t e;
                check("sb1_depth", q1.size(), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("locked1", int'(locked1), e.locked);
                    check("fail1", int'(fail1), e.fail);
                    check("trim1", int'(trim1), e.trim);
                    check("nmeas1", nmeas1, e.nmeas);
                end
                done_cnt1++;
            end
        end
    end

    task automatic run0(input int tgt, input int tl, input bit push,
                        input int el, input int ef, input int ei,
                        input int et, input int en);
        exp_t e;
        e = '{el, ef, ei, et, en};
        if (push) q0.push_back(e);
        target = 8'(tgt);
        tol = 8'(tl);
        nmeas0 = 0;
        gap0 = 0;
        first0 = 1'b1;
        busy_bad0 = 0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        active0 = 1'b1;
        check("start_clears", int'(locked0 | fail0 | inexact0), 0);
        check("start_busy", int'(busy0), 1);
    endtask

    task automatic wait_done0(input int budget);
        int base;
        base = done_cnt0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt0 != base) break;
        end
        check("done0_seen", int'(done_cnt0 != base), 1);
        repeat (3) @(negedge clk);
        check("done0_pulses", done_cnt0 - base, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_trim", int'(trim0), 0);
        check("rst_outs", int'({req0, busy0, done0, locked0, fail0, inexact0}), 0);
        check("rst_trim1", int'(trim1), 0);
        rst = 1'b0;
        @(negedge clk);

        run0(185, 2, 1'b1, 1, 0, 0, 2, 3);
        wait_done0(400);

        run0(180, 2, 1'b1, 1, 0, 1, 2, 3);
        wait_done0(400);
        run0(179, 2, 1'b1, 1, 0, 1, 1, 3);
        wait_done0(400);

        run0(250, 0, 1'b1, 0, 1, 0, 7, 8);
        wait_done0(800);
        check("sat_hold", int'(trim0), 7);

        begin
            exp_t e;
            int base;
            e = '{0, 1, 0, 2, 3};
            q1.push_back(e);
            target = 8'd250;
            tol = 8'd0;
            nmeas1 = 0;
            base = done_cnt1;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            for (int i = 0; i < 400; i++) begin
                @(negedge clk);
                if (done_cnt1 != base) break;
            end
            check("done1_seen", int'(done_cnt1 != base), 1);
        end

        run0(185, 2, 1'b0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            if (req0) break;
            @(negedge clk);
        end
        check("abort_in_measure", int'(req0), 1);
        active0 = 1'b0;
        rst = 1'b1;
        inj0 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        inj0 = 1'b0;
        check("abort_trim", int'(trim0), 0);
        check("abort_outs", int'({req0, busy0, done0, locked0, fail0, inexact0}), 0);
        @(negedge clk);

        run0(185, 2, 1'b1, 1, 0, 0, 2, 3);
        repeat (2) @(negedge clk);
        inj0 = 1'b1;
        @(negedge clk);
        inj0 = 1'b0;
        target = 8'd250;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done0(400);

        run0(165, 0, 1'b1, 1, 0, 0, 0, 1);
        wait_done0(200);
        run0(185, 2, 1'b1, 1, 0, 0, 2, 3);
        wait_done0(400);

        check("sb0_drained", q0.size(), 0);
        check("sb1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
